// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state codes,
// the buffered {pc, inst} entry type and PC helpers.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2,
    FETCH_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous power-of-two FIFO with flush; holds fetched {pc, inst} entries
// and is also used as the in-flight request-address queue.
module if_fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head_data,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CntW'(Depth));
  assign count     = cnt_q;
  assign head_data = mem_q[rd_q];

  // A full FIFO may still accept a push when its head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word requests,
// buffers in-order responses and flushes on redirect. Optional MISALIGN_TRAP_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  last_pc_q;
  logic [CntW-1:0] drop_q, drop_d;

  logic            req_accept, redirect_act, misalign;
  logic            resp_live, resp_stale;
  logic [CntW-1:0] outstanding, inst_count, drop_after, out_after, drop_redir;
  logic [CntW:0]   credit_used;

  logic [31:0]     resp_pc;
  logic            pcq_full, pcq_empty;
  logic            inst_push, inst_pop, inst_full, inst_empty;
  fetch_entry_t    inst_push_data, inst_head;

  assign req_accept   = imem_req_valid && imem_req_ready;
  assign redirect_act = redirect_valid && (state_q != FETCH_BOOT);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Responses return in order, so stale ones always precede live ones.
  assign resp_stale = imem_resp_valid && (drop_q != '0);
  assign resp_live  = imem_resp_valid && (drop_q == '0);

  assign drop_after  = drop_q - CntW'(resp_stale);
  assign out_after   = outstanding + CntW'(req_accept) - CntW'(resp_live);
  assign drop_redir  = drop_after + out_after;
  assign credit_used = {1'b0, outstanding} + {1'b0, inst_count};

  // Addresses of requests accepted by memory and not yet answered.
  if_fetch_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_pc_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_act),
    .push      (req_accept),
    .push_data (pc_q),
    .pop       (resp_live),
    .head_data (resp_pc),
    .count     (outstanding),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  assign inst_push      = resp_live && (state_q == FETCH_RUN);
  assign inst_pop       = inst_valid && inst_ready;
  assign inst_push_data = '{pc: resp_pc, inst: imem_resp_data};

  if_fetch_fifo #(
    .Width ($bits(fetch_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_inst_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_act),
    .push      (inst_push),
    .push_data (inst_push_data),
    .pop       (inst_pop),
    .head_data (inst_head),
    .count     (inst_count),
    .full      (inst_full),
    .empty     (inst_empty)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_BOOT:  state_d = FETCH_RUN;
      FETCH_FLUSH: if (drop_after == '0) state_d = FETCH_RUN;
      default:     state_d = state_q;
    endcase
    if (redirect_act) begin
      if (misalign) begin
        state_d = FETCH_HALT;
      end else if (drop_redir == '0) begin
        state_d = FETCH_RUN;
      end else begin
        state_d = FETCH_FLUSH;
      end
    end
  end

  // FSM outputs: request only while total credit is below the buffer depth.
  always_comb begin
    imem_req_valid = 1'b0;
    if (state_q == FETCH_RUN) begin
      imem_req_valid = (credit_used < (CntW + 1)'(FIFO_DEPTH));
    end
  end

  assign imem_addr = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_act) begin
      pc_d = align_pc(redirect_pc);
    end else if (req_accept) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  assign drop_d = redirect_act ? drop_redir : drop_after;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      drop_q    <= '0;
      last_pc_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      last_pc_q <= inst_pc;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
    end else if (redirect_act) begin
      fetch_misaligned <= misalign;
    end
  end
`endif

  assign inst_valid = !inst_empty;
  assign inst       = inst_empty ? INST_NOP : inst_head.inst;
  assign inst_pc    = inst_empty ? last_pc_q : inst_head.pc;

  // Credit accounting makes these unreachable with a compliant memory.
  a_no_resp_when_full: assert property (@(posedge clock) disable iff (reset)
    !(inst_push && inst_full));
  a_resp_has_request: assert property (@(posedge clock) disable iff (reset)
    !(resp_live && pcq_empty));
  a_no_req_over_credit: assert property (@(posedge clock) disable iff (reset)
    !(req_accept && pcq_full));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a fixed-latency in-order
// memory model. Trap checks compile in when MISALIGN_TRAP_EN is defined.
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc;
  int    lat = 1;
  int    accepts;
  int    passed = 0;
  int    total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_resp();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  // One clock edge; memory sees this cycle's handshake, redirect lasts one edge.
  task automatic cycle();
    logic        acc;
    logic        rv;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    rv  = imem_resp_valid;
    @(posedge clock);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (rv) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{addr: a, due: cyc + lat - 1});
      accepts++;
    end
    drive_resp();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mq.delete();
    accepts = 0;
    imem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  // Waits (bounded) for the next instruction, checks it, then consumes it.
  task automatic expect_inst(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    while (!inst_valid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_inst"}, inst, mem_word(pc));
    cycle();
  endtask

  initial begin
    // Reset values while reset is held.
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Streaming with latency 1 and a ready decoder.
    do_reset();
    check("boot_no_req", 32'(imem_req_valid), 32'd0);
    cycle();
    check("run_req_valid", 32'(imem_req_valid), 32'd1);
    check("run_addr0", imem_addr, 32'h0);
    cycle();
    check("c2_inst_valid", 32'(inst_valid), 32'd0);
    check("c2_addr4", imem_addr, 32'h4);
    cycle();
    check("c3_inst_valid", 32'(inst_valid), 32'd1);
    check("c3_inst_pc", inst_pc, 32'h0);
    check("c3_inst", inst, 32'hC0DE_0003);
    cycle();
    expect_inst("s1_4", 32'h4);
    check("s1_empty_valid", 32'(inst_valid), 32'd0);
    check("s1_empty_nop", inst, 32'h0000_0013);
    check("s1_empty_pc_hold", inst_pc, 32'h4);
    expect_inst("s1_8", 32'h8);
    expect_inst("s1_c", 32'hC);

    // Back-pressure: decoder stalled.
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check("bp_accepts", 32'(accepts), 32'd2);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_inst_valid", 32'(inst_valid), 32'd1);
    check("bp_inst_pc", inst_pc, 32'h0);
    check("bp_inst", inst, mem_word(32'h0));
    inst_ready = 1'b1;
    expect_inst("bp_0", 32'h0);
    check("bp_resume_valid", 32'(imem_req_valid), 32'd1);
    check("bp_resume_addr", imem_addr, 32'h8);
    expect_inst("bp_4", 32'h4);
    expect_inst("bp_8", 32'h8);

    // Reset while the buffer holds two entries.
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    check("mr_pre_valid", 32'(inst_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_inst_valid", 32'(inst_valid), 32'd0);
    check("mr_req_valid", 32'(imem_req_valid), 32'd0);
    check("mr_inst_nop", inst, 32'h0000_0013);
    check("mr_addr", imem_addr, 32'h0);
    do_reset();
    inst_ready = 1'b1;
    expect_inst("mr_0", 32'h0);

    // Latency 3, redirect with two requests outstanding.
    lat = 3;
    do_reset();
    cycle();
    cycle();
    cycle();
    check("fl_accepts", 32'(accepts), 32'd2);
    check("fl_pre_req", 32'(imem_req_valid), 32'd0);
    redirect_pc = 32'h100;
    redirect_valid = 1'b1;
    cycle();
    check("fl_req0", 32'(imem_req_valid), 32'd0);
    check("fl_inst_valid", 32'(inst_valid), 32'd0);
    cycle();
    check("fl_req1", 32'(imem_req_valid), 32'd0);
    cycle();
    check("fl_req_restart", 32'(imem_req_valid), 32'd1);
    check("fl_addr", imem_addr, 32'h100);
    expect_inst("fl_100", 32'h100);
    expect_inst("fl_104", 32'h104);

    // Redirect in the same cycle as an accept and a response.
    lat = 1;
    do_reset();
    cycle();
    cycle();
    check("co_req_valid", 32'(imem_req_valid), 32'd1);
    check("co_resp_valid", 32'(imem_resp_valid), 32'd1);
    redirect_pc = 32'h40;
    redirect_valid = 1'b1;
    cycle();
    check("co_inst_valid", 32'(inst_valid), 32'd0);
    check("co_flush_req", 32'(imem_req_valid), 32'd0);
    cycle();
    check("co_req_restart", 32'(imem_req_valid), 32'd1);
    check("co_addr", imem_addr, 32'h40);
    expect_inst("co_40", 32'h40);
    expect_inst("co_44", 32'h44);
    expect_inst("co_48", 32'h48);

`ifdef MISALIGN_TRAP_EN
    // Misaligned redirect traps until an aligned redirect.
    do_reset();
    cycle();
    check("mt_flag_rst", 32'(fetch_misaligned), 32'd0);
    redirect_pc = 32'h102;
    redirect_valid = 1'b1;
    cycle();
    check("mt_flag_set", 32'(fetch_misaligned), 32'd1);
    cycle();
    cycle();
    check("mt_no_req", 32'(imem_req_valid), 32'd0);
    check("mt_flag_hold", 32'(fetch_misaligned), 32'd1);
    redirect_pc = 32'h200;
    redirect_valid = 1'b1;
    cycle();
    check("mt_flag_clr", 32'(fetch_misaligned), 32'd0);
    check("mt_req", 32'(imem_req_valid), 32'd1);
    check("mt_addr", imem_addr, 32'h200);
    expect_inst("mt_200", 32'h200);
`else
    // Low target bits are ignored.
    do_reset();
    cycle();
    redirect_pc = 32'h102;
    redirect_valid = 1'b1;
    cycle();
    check("al_flush_req", 32'(imem_req_valid), 32'd0);
    cycle();
    check("al_req", 32'(imem_req_valid), 32'd1);
    check("al_addr", imem_addr, 32'h100);
    expect_inst("al_100", 32'h100);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
